// File: rtl/mem_copier_pkg.sv
// Shared definitions for the block copy/fill engine: FSM state encoding and op codes.
package mem_copier_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

endpackage

// File: rtl/mem_copier.sv
// RAM bus initiator performing word-serial block copies and fills.
// All RAM-facing outputs are registered, so mem_dout never reaches an output combinationally.
module mem_copier
  import mem_copier_pkg::*;
#(
  parameter int bits  = 32,
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [bits-1:0]  src,
  input  logic [bits-1:0]  dst,
  input  logic [bits-1:0]  len,
  input  logic [width-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             mem_we,
  output logic [bits-1:0]  mem_adr,
  output logic [width-1:0] mem_din,
  input  logic [width-1:0] mem_dout
);

  state_e           state_q, state_d;
  logic [bits-1:0]  sp_q, sp_d;
  logic [bits-1:0]  dp_q, dp_d;
  logic [bits-1:0]  rem_q, rem_d;
  logic [width-1:0] buf_q, buf_d;
  logic             op_q, op_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             we_q, we_d;
  logic [bits-1:0]  adr_q, adr_d;
  logic [width-1:0] din_q, din_d;

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    dp_d    = dp_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    op_d    = op_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sp_d  = src;
          dp_d  = dst;
          rem_d = len;
          op_d  = op;
          if (op == OP_FILL) begin
            buf_d = pattern;
          end
          if (len == '0) begin
            state_d = DONE;
          end else if (op == OP_FILL) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        buf_d   = mem_dout;
        sp_d    = sp_q + bits'(1);
        state_d = WRITE;
      end
      WRITE: begin
        dp_d  = dp_q + bits'(1);
        rem_d = rem_q - bits'(1);
        if (rem_q == bits'(1)) begin
          state_d = DONE;
        end else if (op_q == OP_COPY) begin
          state_d = READ;
        end else begin
          state_d = WRITE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the state being entered so they can be registered
    // and still line up with that state's cycle.
    busy_d = 1'b0;
    done_d = 1'b0;
    we_d   = 1'b0;
    adr_d  = '0;
    din_d  = '0;
    case (state_d)
      READ: begin
        busy_d = 1'b1;
        adr_d  = sp_d;
      end
      WRITE: begin
        busy_d = 1'b1;
        we_d   = 1'b1;
        adr_d  = dp_d;
        din_d  = buf_d;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sp_q    <= '0;
      dp_q    <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      op_q    <= OP_COPY;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      dp_q    <= dp_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      din_q   <= din_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign mem_we  = we_q;
  assign mem_adr = adr_q;
  assign mem_din = din_q;

endmodule

// File: doc/mem_copier.md
# mem_copier

Bus-initiator engine that drives the single-port data RAM (async read, write on rising clock) to perform block copies and block fills without CPU involvement. It sits beside the datapath on the RAM's `we`/`adr`/`din`/`dout` port, muxed in by the top level while `busy` is high. It is the requester side of the RAM interface: it generates every address, write enable and write datum, and consumes read data combinationally.

## Interface
- `bits`, 32, address width; also width of `len`
- `width`, 32, data word width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  command strobe, sampled only in IDLE
- `op`  in  1  0 = copy, 1 = fill
- `src`  in  bits  copy source base word address (ignored for fill)
- `dst`  in  bits  destination base word address
- `len`  in  bits  word count
- `pattern`  in  width  fill value (ignored for copy)
- `busy`  out  1  high in READ and WRITE
- `done`  out  1  one-cycle completion pulse
- `mem_we`  out  1  to RAM `we`
- `mem_adr`  out  bits  to RAM `adr`
- `mem_din`  out  width  to RAM `din`
- `mem_dout`  in  width  from RAM `dout`, valid same cycle as `mem_adr`

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: `start`=1 at an edge latches `src`, `dst`, `len`, `op`, `pattern` into `sp`, `dp`, `rem`, `op_r`, `buf` (fill: `buf`=`pattern`). Next state: DONE if `len`=0; else WRITE if fill; else READ.
- READ (copy only): `mem_adr`=`sp`, `mem_we`=0. At edge: `buf`<=`mem_dout`, `sp`<=`sp`+1, go WRITE.
- WRITE: `mem_adr`=`dp`, `mem_we`=1, `mem_din`=`buf`. At edge: `dp`<=`dp`+1, `rem`<=`rem`-1; if `rem`=1 go DONE, else READ (copy) or WRITE (fill).
- DONE: `done`=1, `busy`=0, all mem outputs zero; next IDLE unconditionally.
- IDLE and DONE: `mem_we`=0, `mem_adr`=0, `mem_din`=0.
- Pointer arithmetic modulo 2^`bits`; wrap-around is silent and legal.
- Copy is strictly ascending and word-serial: overlap with `src` < `dst` < `src`+`len` yields forward-propagation semantics (source word re-read after being overwritten); this is the defined result.
- `start` in READ, WRITE or DONE is ignored; no queuing.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_we`=0, `mem_adr`=0, `mem_din`=0; state IDLE; `sp`, `dp`, `rem`, `buf` = 0.
- `start` sampled at edge E0. Copy of N≥1 words: `busy` high cycles 1..2N, `done` high cycle 2N+1. Fill of N≥1: `busy` cycles 1..N, `done` cycle N+1. `len`=0: `done` in cycle 1, no write issued.
- Next `start` accepted at edge ending the DONE cycle+1 (i.e. once back in IDLE); back-to-back minimum gap one IDLE cycle.
- Memory outputs are functions of registered state only (Moore); `mem_dout` is captured on the READ-cycle edge, no combinational path from `mem_dout` to any output.
- `rst` mid-operation: state IDLE and all outputs zero from the cycle after the reset edge; the write in a WRITE cycle coinciding with the reset edge still commits (RAM sees `we`=1 at that edge); no further writes; `done` not pulsed.

## Structure
- Shared package: state encoding constants (IDLE, READ, WRITE, DONE) and op codes (OP_COPY=0, OP_FILL=1).
- No RTL sub-module; single FSM plus pointer/counter datapath. Bench instantiates the existing RAM (depth 128) on the mem ports.

## Test plan
- Copy: RAM[0..3]=11,22,33,44; src=0,dst=64,len=4 -> RAM[64..67]=11,22,33,44; `done` exactly in cycle 9; 4 `mem_we` pulses.
- Fill: dst=10,len=5,pattern=0xDEADBEEF -> RAM[10..14]=0xDEADBEEF, RAM[9],RAM[15] unchanged; `done` in cycle 6.
- len=0 -> `done` in cycle 1, `busy` never high, no `mem_we`.
- Overlap: RAM[0..3]=1,2,3,4; src=0,dst=1,len=3 -> RAM[0..3]=1,1,1,1.
- `start` pulsed during busy with different args -> ignored; only first command's writes occur.
- `rst` asserted in cycle 3 of an 8-word copy -> exactly one word written (RAM[dst]), outputs zero thereafter, `done` never asserted; a fresh command then completes normally.
